alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock domain.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 s  input  1  start; sampled only in WAIT.
REQ-004 in  input  16  instruction word; fields [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8, [4:0] imm5.
REQ-005 w  output  1  high only in WAIT (ready for a new instruction).
REQ-006 nsel  output  3  one-hot register-file select: 100 Rn, 010 Rd, 001 Rm, 000 none.
REQ-007 vsel  output  2  writeback source: 00 datapath C, 10 sximm8.
REQ-008 loada, loadb, loadc, loads  output  1 each  register load enables for A, B, C, status.
REQ-009 write  output  1  register-file write enable.
REQ-010 asel, bsel  output  1 each  asel=1 forces ALU A input to zero; bsel=1 selects sximm5 for B.
REQ-011 ALUop  output  2  00 add, 01 subtract, 10 AND, 11 NOT B.
REQ-012 shift  output  2  shifter control for B path.
REQ-013 sximm8, sximm5  output  16 each  sign-extended ir[7:0], ir[4:0].
REQ-014 err  output  1  one-cycle pulse on an undecodable instruction.

Function
REQ-015 Instruction register ir (16 b) SHALL load from in on the edge where state=WAIT and s=1; ir SHALL hold otherwise; sximm8/sximm5 SHALL derive combinationally from ir.
REQ-016 Outputs SHALL be Moore (function of state and ir only); unlisted outputs per state SHALL be 0.
REQ-017 States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, CMP, WRITE_REG, ERR.
REQ-018 WAIT: w=1; s=1 -> DECODE, else stay.
REQ-019 DECODE: opcode 110/op 10 (MOV Rn,#imm8) -> WRITE_IMM; 110/00 (MOV Rd,Rm) -> GET_B; 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A; 101/11 MVN -> GET_B; any other -> ERR.
REQ-020 WRITE_IMM: nsel=100, vsel=10, write=1; -> WAIT.
REQ-021 GET_A: nsel=100, loada=1; -> GET_B.
REQ-022 GET_B: nsel=001, loadb=1; -> CMP if ir is CMP, else ALU.
REQ-023 ALU: loadc=1, shift=ir[4:3], bsel=0; MOV: asel=1, ALUop=00; ADD/AND/MVN: asel=0, ALUop=ir[12:11]; -> WRITE_REG.
REQ-024 CMP: loads=1, ALUop=01, shift=ir[4:3], asel=0, bsel=0; -> WAIT; no register write.
REQ-025 WRITE_REG: nsel=010, vsel=00, write=1; -> WAIT.
REQ-026 ERR: err=1; -> WAIT; no load or write.
REQ-027 Latency from s-accept edge to return to WAIT: MOV imm 3, MOV reg/MVN 5, ADD/AND 6, CMP 5, illegal 3 cycles.
REQ-028 s outside WAIT SHALL be ignored; changes to in outside WAIT SHALL not affect the instruction in flight.
REQ-029 s held high continuously SHALL accept a new instruction on every entry to WAIT (WAIT lasts exactly 1 cycle).
REQ-030 shift SHALL be 00 in all states other than ALU and CMP.
REQ-031 write and any load enable SHALL never assert in the same cycle.

Reset
REQ-032 reset=1 at a rising edge SHALL force state=WAIT and ir=0, overriding s and all transitions.
REQ-033 After reset: w=1, all other outputs 0 (sximm8=sximm5=0).
REQ-034 Reset asserted mid-instruction SHALL abort it; no write or load SHALL occur in the cycle following the reset edge.

Verification
REQ-035 reset, then in=16'hD2F6 (MOV R2,#-10), s pulse -> DECODE, WRITE_IMM with nsel=100, vsel=10, write=1, sximm8=16'hFFF6, then w=1.
REQ-036 in=16'hA0A9 (ADD R5,R0,R1 LSL#1) -> loada(nsel=100), loadb(nsel=001), loadc with ALUop=00, shift=01, write with nsel=010; 6 cycles to w=1.
REQ-037 in=16'hA902 (CMP R1,R2) -> loads=1 with ALUop=01 in CMP state; write never asserts; 5 cycles.
REQ-038 in=16'hE000 (illegal opcode 111) -> err=1 for exactly one cycle, no load/write, back in WAIT after 3 cycles.
REQ-039 reset asserted during GET_B of an ADD -> next cycle w=1, loadc=0, write=0; subsequent instruction executes normally.
REQ-040 s held high with in changed during execution -> each instruction uses the word sampled in WAIT; back-to-back MOV imm completes every 3 cycles.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction register, decoder and Moore control FSM for a
// small register-file datapath. Accepts one 16-bit instruction per visit to
// WAIT and steps the datapath through read, execute and writeback.

module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  nsel,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        err
);

    // Opcode and op field encodings.
    localparam logic [2:0] OpcMov = 3'b110;
    localparam logic [2:0] OpcAlu = 3'b101;
    localparam logic [1:0] OpMovImm = 2'b10;
    localparam logic [1:0] OpMovReg = 2'b00;
    localparam logic [1:0] OpAdd    = 2'b00;
    localparam logic [1:0] OpCmp    = 2'b01;
    localparam logic [1:0] OpAnd    = 2'b10;
    localparam logic [1:0] OpMvn    = 2'b11;

    // Register-file select encodings.
    localparam logic [2:0] NselNone = 3'b000;
    localparam logic [2:0] NselRn   = 3'b100;
    localparam logic [2:0] NselRd   = 3'b010;
    localparam logic [2:0] NselRm   = 3'b001;

    // Writeback source encodings.
    localparam logic [1:0] VselC    = 2'b00;
    localparam logic [1:0] VselImm8 = 2'b10;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;

    typedef enum logic [3:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StAlu,
        StCmp,
        StWriteReg,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q;

    // Instruction fields, all taken from the latched word so that changes on
    // 'in' never disturb an instruction already in flight.
    logic [2:0] opcode;
    logic [1:0] op;
    logic [1:0] sh;
    logic       is_mov;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;
    logic       needs_a;
    logic       unused_ir;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign sh     = ir_q[4:3];

    // Register numbers are consumed by the datapath through nsel, not here.
    assign unused_ir = ^ir_q[10:8];

    assign is_mov     = (opcode == OpcMov);
    assign is_mov_imm = is_mov && (op == OpMovImm);
    assign is_mov_reg = is_mov && (op == OpMovReg);
    assign is_alu     = (opcode == OpcAlu);
    assign is_cmp     = is_alu && (op == OpCmp);
    assign is_mvn     = is_alu && (op == OpMvn);
    // ADD, CMP and AND read Rn into A; MOV reg and MVN only need B.
    assign needs_a    = is_alu && ((op == OpAdd) || (op == OpCmp) || (op == OpAnd));

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    // Instruction register: captures 'in' only on the accept edge in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= 16'h0000;
        end else if ((state_q == StWait) && s) begin
            ir_q <= in;
        end
    end

    // State register with synchronous reset overriding every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait: begin
                if (s) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_mov_imm) begin
                    state_d = StWriteImm;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = StGetB;
                end else if (needs_a) begin
                    state_d = StGetA;
                end else begin
                    state_d = StErr;
                end
            end
            StWriteImm: state_d = StWait;
            StGetA:     state_d = StGetB;
            StGetB:     state_d = is_cmp ? StCmp : StAlu;
            StAlu:      state_d = StWriteReg;
            StCmp:      state_d = StWait;
            StWriteReg: state_d = StWait;
            StErr:      state_d = StWait;
            default:    state_d = StWait;
        endcase
    end

    // Moore outputs: every output defaults low and is raised per state.
    always_comb begin
        w     = 1'b0;
        nsel  = NselNone;
        vsel  = VselC;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        write = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        ALUop = AluAdd;
        shift = 2'b00;
        err   = 1'b0;
        unique case (state_q)
            StWait: begin
                w = 1'b1;
            end
            StDecode: begin
            end
            StWriteImm: begin
                nsel  = NselRn;
                vsel  = VselImm8;
                write = 1'b1;
            end
            StGetA: begin
                nsel  = NselRn;
                loada = 1'b1;
            end
            StGetB: begin
                nsel  = NselRm;
                loadb = 1'b1;
            end
            StAlu: begin
                loadc = 1'b1;
                shift = sh;
                // MOV reg passes shifted B through by adding it to a zeroed A.
                if (is_mov) begin
                    asel  = 1'b1;
                    ALUop = AluAdd;
                end else begin
                    ALUop = op;
                end
            end
            StCmp: begin
                loads = 1'b1;
                ALUop = AluSub;
                shift = sh;
            end
            StWriteReg: begin
                nsel  = NselRd;
                vsel  = VselC;
                write = 1'b1;
            end
            StErr: begin
                err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer. Each task drives one
// instruction scenario and compares the packed control outputs per cycle.

module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [2:0]  nsel;
    logic [1:0]  vsel;
    logic        loada, loadb, loadc, loads, write, asel, bsel, err;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm8, sximm5;

    int checks;
    int errors;

    alu_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .in     (in),
        .w      (w),
        .nsel   (nsel),
        .vsel   (vsel),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .write  (write),
        .asel   (asel),
        .bsel   (bsel),
        .ALUop  (ALUop),
        .shift  (shift),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of the control outputs:
    // {w, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel, ALUop, shift, err}
    logic [17:0] obs;
    assign obs = {w, nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel, ALUop, shift,
                  err};

    function automatic logic [17:0] ev(input logic w_e, input logic [2:0] n,
                                       input logic [1:0] v, input logic [3:0] ld,
                                       input logic wr, input logic a, input logic b,
                                       input logic [1:0] op, input logic [1:0] sh,
                                       input logic e);
        return {w_e, n, v, ld, wr, a, b, op, sh, e};
    endfunction

    localparam logic [17:0] XWait   = 18'h20000;
    localparam logic [17:0] XDecode = 18'h00000;

    // Write and any load enable must never coincide.
    always @(negedge clk) begin
        checks++;
        if (write && (loada || loadb || loadc || loads)) begin
            errors++;
            $display("FAIL write_load_overlap: write=%b loads=%b%b%b%b, required no overlap",
                     write, loada, loadb, loadc, loads);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        s     = 1'b1;
        in    = 16'hD2F6;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== XWait) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs, XWait);
        end
        checks++;
        if ({sximm8, sximm5} !== 32'h0) begin
            errors++;
            $display("FAIL reset_imm: got %h %h want 0000 0000", sximm8, sximm5);
        end
        reset = 1'b0;
        s     = 1'b0;
    endtask

    task automatic test_mov_imm();
        logic [17:0] x [3];
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b100, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[2] = XWait;
        in = 16'hD2F6;
        s  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            s  = 1'b0;
            in = 16'h1234;
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL mov_imm cycle %0d: got %b want %b", i, obs, x[i]);
            end
        end
        checks++;
        if (sximm8 !== 16'hFFF6) begin
            errors++;
            $display("FAIL mov_imm_sximm8: got %h want FFF6", sximm8);
        end
    endtask

    task automatic test_add();
        logic [17:0] x [6];
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b100, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[2] = ev(1'b0, 3'b001, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[3] = ev(1'b0, 3'b000, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
        x[4] = ev(1'b0, 3'b010, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[5] = XWait;
        in = 16'hA0A9;
        s  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            // Pulse s with a different word mid-flight; it must be ignored.
            s  = (i == 1);
            in = 16'hE000;
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL add cycle %0d: got %b want %b", i, obs, x[i]);
            end
        end
        checks++;
        if ({sximm8, sximm5} !== {16'hFFA9, 16'h0009}) begin
            errors++;
            $display("FAIL add_imm: got %h %h want FFA9 0009", sximm8, sximm5);
        end
    endtask

    task automatic test_and();
        logic [17:0] x [6];
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b100, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[2] = ev(1'b0, 3'b001, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[3] = ev(1'b0, 3'b000, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0);
        x[4] = ev(1'b0, 3'b010, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[5] = XWait;
        in = 16'hB0A9;
        s  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            s  = 1'b0;
            in = 16'hD2F6;
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL and cycle %0d: got %b want %b", i, obs, x[i]);
            end
        end
    endtask

    task automatic test_cmp();
        logic [17:0] x [5];
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b100, 2'b00, 4'b1000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[2] = ev(1'b0, 3'b001, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[3] = ev(1'b0, 3'b000, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        x[4] = XWait;
        in = 16'hA902;
        s  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            s  = 1'b0;
            in = 16'hA0A9;
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL cmp cycle %0d: got %b want %b", i, obs, x[i]);
            end
        end
    endtask

    task automatic test_mov_reg();
        logic [17:0] x [5];
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b001, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[2] = ev(1'b0, 3'b000, 2'b00, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0);
        x[3] = ev(1'b0, 3'b010, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[4] = XWait;
        in = 16'hC0B0;
        s  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            s  = 1'b0;
            in = 16'hFFFF;
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL mov_reg cycle %0d: got %b want %b", i, obs, x[i]);
            end
        end
    endtask

    task automatic test_mvn();
        logic [17:0] x [5];
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b001, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[2] = ev(1'b0, 3'b000, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0);
        x[3] = ev(1'b0, 3'b010, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[4] = XWait;
        in = 16'hB87C;
        s  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            s  = 1'b0;
            in = 16'h0000;
            checks++;
            if (obs !== x[i]) begin
                errors++;
                $display("FAIL mvn cycle %0d: got %b want %b", i, obs, x[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] words [3];
        logic [17:0] x [3];
        words[0] = 16'hE000;
        words[1] = 16'hC800;
        words[2] = 16'h0000;
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        x[2] = XWait;
        for (int k = 0; k < 3; k++) begin
            in = words[k];
            s  = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                s  = 1'b0;
                in = 16'hD2F6;
                checks++;
                if (obs !== x[i]) begin
                    errors++;
                    $display("FAIL illegal %h cycle %0d: got %b want %b", words[k], i, obs,
                             x[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        in = 16'hA0A9;
        s  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            s = 1'b0;
        end
        // Now in GET_B of the ADD.
        checks++;
        if (obs !== ev(1'b0, 3'b001, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_getb: got %b", obs);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (obs !== XWait) begin
            errors++;
            $display("FAIL reset_mid_abort: got %b want %b", obs, XWait);
        end
        checks++;
        if (sximm8 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_ir: got %h want 0000", sximm8);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== XWait) begin
            errors++;
            $display("FAIL reset_mid_idle: got %b want %b", obs, XWait);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] x [6];
        logic [15:0] nxt [6];
        logic [15:0] imm [6];
        x[0] = XDecode;
        x[1] = ev(1'b0, 3'b100, 2'b10, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        x[2] = XWait;
        x[3] = XDecode;
        x[4] = x[1];
        x[5] = XWait;
        nxt[0] = 16'hD305; nxt[1] = 16'hD305; nxt[2] = 16'hD305;
        nxt[3] = 16'hE000; nxt[4] = 16'hE000; nxt[5] = 16'hE000;
        imm[0] = 16'hFFF6; imm[1] = 16'hFFF6; imm[2] = 16'hFFF6;
        imm[3] = 16'h0005; imm[4] = 16'h0005; imm[5] = 16'h0005;
        in = 16'hD2F6;
        s  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in = nxt[i];
            if (i == 4) begin
                s = 1'b0;
            end
            checks++;
            if ({obs, sximm8} !== {x[i], imm[i]}) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b/%h want %b/%h", i, obs, sximm8,
                         x[i], imm[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== XWait) begin
            errors++;
            $display("FAIL back_to_back_idle: got %b want %b", obs, XWait);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        s      = 1'b0;
        in     = 16'h0000;
        test_reset();
        test_mov_imm();
        test_add();
        test_and();
        test_cmp();
        test_mov_reg();
        test_mvn();
        test_illegal();
        test_reset_mid();
        test_mov_imm();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
